// File: rtl/tcb_lite_htif_sub_if.sv
// TCB-lite request/response bundle between the LSU manager and the HTIF
// subordinate.
//   vld/rdy : request handshake (transfer when both high)
//   wen     : write enable
//   adr     : byte address
//   siz     : log2 transfer size
//   wdt     : write data
//   rdt     : read data, valid one cycle after the transfer
interface tcb_lite_htif_sub_if #(
  parameter int ADR_W = 5,
  parameter int XLEN  = 32
);
  logic             vld;
  logic             rdy;
  logic             wen;
  logic [ADR_W-1:0] adr;
  logic [1:0]       siz;
  logic [XLEN-1:0]  wdt;
  logic [XLEN-1:0]  rdt;

  modport master (output vld, wen, adr, siz, wdt, input  rdy, rdt);
  modport slave  (input  vld, wen, adr, siz, wdt, output rdy, rdt);
endinterface

// File: rtl/tcb_lite_htif_sub.sv
// HTIF tohost/fromhost mailbox as a TCB-lite subordinate.
// Lets a core signal test exit and print console characters without a
// behavioural HTIF model.
// Ports:
//   clk      : clock
//   rst      : asynchronous reset, active low
//   tcb      : TCB-lite subordinate side (vld/rdy/wen/adr/siz/wdt/rdt)
//   con_vld  : console byte valid (FIFO not empty)
//   con_rdy  : console byte ready (pops the FIFO head)
//   con_dat  : console byte (FIFO head)
//   exit_vld : sticky test-finished flag
//   exit_cod : exit code, 0 means pass
// Register map (word offsets):
//   0x00 TOHOST_LO, 0x04 TOHOST_HI, 0x08 FROMHOST_LO, 0x0C FROMHOST_HI,
//   0x10 STATUS {16'h0, count[7:0], 5'h0, exit_vld, full, empty}
module tcb_lite_htif_sub #(
  parameter int ADR_W  = 5,
  parameter int FIFO_D = 8,
  parameter int XLEN   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  tcb_lite_htif_sub_if.slave     tcb,
  output logic                   con_vld,
  input  logic                   con_rdy,
  output logic [7:0]             con_dat,
  output logic                   exit_vld,
  output logic [30:0]            exit_cod
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;
  localparam int WRD_W = ADR_W - 2;

  localparam logic [WRD_W-1:0] W_TOHOST_LO   = WRD_W'(0);
  localparam logic [WRD_W-1:0] W_TOHOST_HI   = WRD_W'(1);
  localparam logic [WRD_W-1:0] W_FROMHOST_LO = WRD_W'(2);
  localparam logic [WRD_W-1:0] W_FROMHOST_HI = WRD_W'(3);
  localparam logic [WRD_W-1:0] W_STATUS      = WRD_W'(4);

  // mailbox registers
  logic [31:0]      tohost_lo_reg;
  logic [31:0]      tohost_hi_reg;
  logic [31:0]      fromhost_lo_reg;
  logic [31:0]      fromhost_hi_reg;
  logic             exit_vld_reg;
  logic [30:0]      exit_cod_reg;
  logic [XLEN-1:0]  rdt_reg;

  // console FIFO
  logic [7:0]       fifo_mem [FIFO_D];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  logic             trn;
  logic             wr_ok;
  logic [WRD_W-1:0] word;
  logic             hi_req;
  logic             is_putchar;
  logic             is_exit_cmd;
  logic             lo_wr;
  logic             hi_wr;
  logic             fl_wr;
  logic             fh_wr;
  logic             exit_set;
  logic [30:0]      exit_cod_next;
  logic [XLEN-1:0]  rd_data;
  logic [31:0]      status;

  assign word  = tcb.adr[ADR_W-1:2];
  // only aligned full-word writes change state; others are still handshaken
  assign wr_ok = tcb.wen && (tcb.siz == 2'd2) && (tcb.adr[1:0] == 2'b00);

  // command word is {wdt, TOHOST_LO}: device in wdt[31:24], cmd in wdt[23:16]
  assign is_putchar  = (tcb.wdt[31:24] == 8'd1) && (tcb.wdt[23:16] == 8'd1);
  assign is_exit_cmd = (tcb.wdt[31:24] == 8'd0) && tohost_lo_reg[0];

  assign fifo_empty = (cnt_reg == '0);
  assign fifo_full  = (cnt_reg == CNT_W'(FIFO_D));
  assign pop        = !fifo_empty && con_rdy;

  // Stall a putchar only when the FIFO is full and no slot frees this cycle.
  assign hi_req  = tcb.vld && wr_ok && (word == W_TOHOST_HI);
  assign tcb.rdy = !(hi_req && is_putchar && fifo_full && !pop);

  assign trn   = tcb.vld && tcb.rdy;
  assign lo_wr = trn && wr_ok && (word == W_TOHOST_LO);
  assign hi_wr = trn && wr_ok && (word == W_TOHOST_HI);
  assign fl_wr = trn && wr_ok && (word == W_FROMHOST_LO);
  assign fh_wr = trn && wr_ok && (word == W_FROMHOST_HI);
  assign push  = hi_wr && is_putchar;

  // Exit is sticky: the first qualifying write wins, later ones are ignored.
  always_comb begin
    exit_set      = 1'b0;
    exit_cod_next = exit_cod_reg;
    if (!exit_vld_reg) begin
      if (lo_wr && tcb.wdt[0] && (tohost_hi_reg == '0)) begin
        exit_set      = 1'b1;
        exit_cod_next = tcb.wdt[31:1];
      end else if (hi_wr && is_exit_cmd) begin
        exit_set      = 1'b1;
        exit_cod_next = tohost_lo_reg[31:1];
      end
    end
  end

  assign status = {16'h0, 8'(cnt_reg), 5'h0, exit_vld_reg, fifo_full, fifo_empty};

  always_comb begin
    rd_data = '0;
    case (word)
      W_TOHOST_LO:   rd_data = tohost_lo_reg;
      W_TOHOST_HI:   rd_data = tohost_hi_reg;
      W_FROMHOST_LO: rd_data = fromhost_lo_reg;
      W_FROMHOST_HI: rd_data = fromhost_hi_reg;
      W_STATUS:      rd_data = status;
      default:       rd_data = '0;
    endcase
  end

  // mailbox registers and read response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tohost_lo_reg   <= '0;
      tohost_hi_reg   <= '0;
      fromhost_lo_reg <= '0;
      fromhost_hi_reg <= '0;
      exit_vld_reg    <= 1'b0;
      exit_cod_reg    <= '0;
      rdt_reg         <= '0;
    end else begin
      if (trn && !tcb.wen) begin
        rdt_reg <= rd_data;
      end
      if (lo_wr) begin
        tohost_lo_reg <= tcb.wdt;
      end
      if (hi_wr) begin
        if (is_putchar) begin
          // acknowledge the character the way the HTIF host does
          tohost_lo_reg   <= '0;
          tohost_hi_reg   <= '0;
          fromhost_lo_reg <= '0;
          fromhost_hi_reg <= 32'h0101_0000;
        end else begin
          tohost_hi_reg <= tcb.wdt;
        end
      end
      if (fl_wr) begin
        fromhost_lo_reg <= tcb.wdt;
      end
      if (fh_wr) begin
        fromhost_hi_reg <= tcb.wdt;
      end
      if (exit_set) begin
        exit_vld_reg <= 1'b1;
        exit_cod_reg <= exit_cod_next;
      end
    end
  end

  // console FIFO storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_D; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (push) begin
      fifo_mem[wr_ptr_reg] <= tohost_lo_reg[7:0];
    end
  end

  // pointers wrap naturally because FIFO_D is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  assign tcb.rdt  = rdt_reg;
  assign con_vld  = !fifo_empty;
  assign con_dat  = fifo_mem[rd_ptr_reg];
  assign exit_vld = exit_vld_reg;
  assign exit_cod = exit_cod_reg;

endmodule

// File: tb/tb_tcb_lite_htif_sub.sv
module tb_tcb_lite_htif_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        con_vld;
  logic        con_rdy;
  logic [7:0]  con_dat;
  logic        exit_vld;
  logic [30:0] exit_cod;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tcb_lite_htif_sub_if #(.ADR_W(5), .XLEN(32)) bus ();

  tcb_lite_htif_sub #(.ADR_W(5), .FIFO_D(8), .XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .tcb      (bus),
    .con_vld  (con_vld),
    .con_rdy  (con_rdy),
    .con_dat  (con_dat),
    .exit_vld (exit_vld),
    .exit_cod (exit_cod)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  adr;
    logic [1:0]  siz;
    logic [31:0] wdt;
    logic        chk_rdt;
    logic [31:0] rdt;
    logic        ev;
    logic [30:0] ec;
    logic        cv;
    logic [7:0]  cd;
  } vec_t;

  vec_t tbl1[$];
  vec_t tbl2[$];

  function automatic vec_t mk(input logic wen, input logic [4:0] adr, input logic [1:0] siz,
                              input logic [31:0] wdt, input logic chk_rdt, input logic [31:0] rdt,
                              input logic ev, input logic [30:0] ec, input logic cv, input logic [7:0] cd);
    vec_t v;
    v.wen = wen; v.adr = adr; v.siz = siz; v.wdt = wdt;
    v.chk_rdt = chk_rdt; v.rdt = rdt;
    v.ev = ev; v.ec = ec; v.cv = cv; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus transfer; called at posedge+1, returns at posedge+1 after the handshake edge.
  task automatic xfer(input logic wen, input logic [4:0] adr, input logic [1:0] siz, input logic [31:0] wdt);
    int n;
    n = 0;
    bus.vld = 1'b1; bus.wen = wen; bus.adr = adr; bus.siz = siz; bus.wdt = wdt;
    @(negedge clk);
    while (!bus.rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.rdy) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: rdy=%0b after %0d cycles, expected 1", bus.rdy, n);
    end
    @(posedge clk);
    #1;
    bus.vld = 1'b0;
    bus.wen = 1'b0;
    $display("txn %s adr=0x%02h siz=%0d wdt=0x%08h rdt=0x%08h exit=%0b/%0d con=%0b/0x%02h",
             wen ? "WR" : "RD", adr, siz, wdt, bus.rdt, exit_vld, exit_cod, con_vld, con_dat);
  endtask

  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    xfer(v.wen, v.adr, v.siz, v.wdt);
    if (v.chk_rdt) chk($sformatf("%s%0d_rdt", tag, idx), bus.rdt, v.rdt);
    chk($sformatf("%s%0d_exit_vld", tag, idx), {31'h0, exit_vld}, {31'h0, v.ev});
    chk($sformatf("%s%0d_exit_cod", tag, idx), {1'b0, exit_cod}, {1'b0, v.ec});
    chk($sformatf("%s%0d_con_vld", tag, idx), {31'h0, con_vld}, {31'h0, v.cv});
    if (v.cv) chk($sformatf("%s%0d_con_dat", tag, idx), {24'h0, con_dat}, {24'h0, v.cd});
  endtask

  initial begin
    bus.vld = 1'b0; bus.wen = 1'b0; bus.adr = '0; bus.siz = 2'd2; bus.wdt = '0;
    con_rdy = 1'b0;

    //          wen adr    siz wdt            chk rdt           ev ec cv cd
    tbl1.push_back(mk(0, 5'h10, 2, 32'h0,          1, 32'h0000_0001, 0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h00, 0, 32'h1,          0, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h01, 2, 32'h1,          0, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(0, 5'h00, 2, 32'h0,          1, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h1C, 2, 32'hFFFF_FFFF,  0, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(0, 5'h1C, 2, 32'h0,          1, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(0, 5'h11, 0, 32'h0,          1, 32'h0000_0001, 0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h00, 2, 32'h2,          0, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h04, 2, 32'h0203_0000,  0, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(0, 5'h04, 2, 32'h0,          1, 32'h0203_0000, 0, 0, 0, 8'h00));
    tbl1.push_back(mk(0, 5'h0C, 2, 32'h0,          1, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h04, 2, 32'h0,          0, 32'h0,         0, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h00, 2, 32'h1,          0, 32'h0,         1, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h00, 2, 32'h7,          0, 32'h0,         1, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h00, 2, 32'h41,         0, 32'h0,         1, 0, 0, 8'h00));
    tbl1.push_back(mk(1, 5'h04, 2, 32'h0101_0000,  0, 32'h0,         1, 0, 1, 8'h41));
    tbl1.push_back(mk(0, 5'h00, 2, 32'h0,          1, 32'h0,         1, 0, 1, 8'h41));
    tbl1.push_back(mk(0, 5'h0C, 2, 32'h0,          1, 32'h0101_0000, 1, 0, 1, 8'h41));
    tbl1.push_back(mk(0, 5'h08, 2, 32'h0,          1, 32'h0,         1, 0, 1, 8'h41));
    tbl1.push_back(mk(0, 5'h10, 2, 32'h0,          1, 32'h0000_0104, 1, 0, 1, 8'h41));
    tbl1.push_back(mk(1, 5'h0C, 2, 32'h0,          0, 32'h0,         1, 0, 1, 8'h41));
    tbl1.push_back(mk(0, 5'h0C, 2, 32'h0,          1, 32'h0,         1, 0, 1, 8'h41));

    // exit through the TOHOST_HI command path, after a fresh reset
    tbl2.push_back(mk(1, 5'h04, 2, 32'h0500_0000,  0, 32'h0,         0, 0, 0, 8'h00));
    tbl2.push_back(mk(1, 5'h00, 2, 32'hB,          0, 32'h0,         0, 0, 0, 8'h00));
    tbl2.push_back(mk(0, 5'h04, 2, 32'h0,          1, 32'h0500_0000, 0, 0, 0, 8'h00));
    tbl2.push_back(mk(1, 5'h04, 2, 32'h0,          0, 32'h0,         1, 5, 0, 8'h00));
    tbl2.push_back(mk(1, 5'h00, 2, 32'h3,          0, 32'h0,         1, 5, 0, 8'h00));
    tbl2.push_back(mk(0, 5'h10, 2, 32'h0,          1, 32'h0000_0005, 1, 5, 0, 8'h00));
    tbl2.push_back(mk(0, 5'h00, 2, 32'h0,          1, 32'h0000_0003, 1, 5, 0, 8'h00));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdt", bus.rdt, 32'h0);
    chk("rst_con_vld", {31'h0, con_vld}, 32'h0);
    chk("rst_exit_vld", {31'h0, exit_vld}, 32'h0);
    chk("rst_exit_cod", {1'b0, exit_cod}, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl1[i]) apply_vec("a", i, tbl1[i]);

    // drain the 'A'
    con_rdy = 1'b1;
    @(posedge clk);
    #1;
    con_rdy = 1'b0;
    chk("drainA_con_vld", {31'h0, con_vld}, 32'h0);

    // fill the FIFO with 'a'..'h' while the console is blocked
    for (int i = 0; i < 8; i++) begin
      xfer(1'b1, 5'h00, 2'd2, 32'h61 + i);
      xfer(1'b1, 5'h04, 2'd2, 32'h0101_0000);
    end
    chk("full_head", {24'h0, con_dat}, 32'h61);
    xfer(1'b0, 5'h10, 2'd2, 32'h0);
    chk("full_status", bus.rdt, 32'h0000_0806);

    // ninth putchar stalls until the console takes one byte
    xfer(1'b1, 5'h00, 2'd2, 32'h69);
    bus.vld = 1'b1; bus.wen = 1'b1; bus.adr = 5'h04; bus.siz = 2'd2; bus.wdt = 32'h0101_0000;
    @(negedge clk);
    chk("stall_rdy0", {31'h0, bus.rdy}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_rdy1", {31'h0, bus.rdy}, 32'h0);
    chk("stall_head", {24'h0, con_dat}, 32'h61);
    @(posedge clk);
    #1;
    con_rdy = 1'b1;
    @(negedge clk);
    chk("release_rdy", {31'h0, bus.rdy}, 32'h1);
    @(posedge clk);
    #1;
    bus.vld = 1'b0; bus.wen = 1'b0; con_rdy = 1'b0;
    $display("txn WR adr=0x04 wdt=0x01010000 (released by pop) con=%0b/0x%02h", con_vld, con_dat);
    chk("release_head", {24'h0, con_dat}, 32'h62);
    xfer(1'b0, 5'h10, 2'd2, 32'h0);
    chk("release_status", bus.rdt, 32'h0000_0806);

    // full FIFO, pop and push in the same cycle
    xfer(1'b1, 5'h00, 2'd2, 32'h6A);
    bus.vld = 1'b1; bus.wen = 1'b1; bus.adr = 5'h04; bus.siz = 2'd2; bus.wdt = 32'h0101_0000;
    con_rdy = 1'b1;
    @(negedge clk);
    chk("pushpop_rdy", {31'h0, bus.rdy}, 32'h1);
    @(posedge clk);
    #1;
    bus.vld = 1'b0; bus.wen = 1'b0; con_rdy = 1'b0;
    $display("txn WR adr=0x04 wdt=0x01010000 (push+pop) con=%0b/0x%02h", con_vld, con_dat);
    xfer(1'b0, 5'h10, 2'd2, 32'h0);
    chk("pushpop_status", bus.rdt, 32'h0000_0806);
    chk("pushpop_head", {24'h0, con_dat}, 32'h63);

    // drain 'c'..'j'
    con_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_vld", i), {31'h0, con_vld}, 32'h1);
      chk($sformatf("drain%0d_dat", i), {24'h0, con_dat}, 32'h63 + i);
      @(posedge clk);
      #1;
    end
    con_rdy = 1'b0;
    chk("drained_con_vld", {31'h0, con_vld}, 32'h0);
    xfer(1'b0, 5'h10, 2'd2, 32'h0);
    chk("drained_status", bus.rdt, 32'h0000_0005);

    // reset during a read drops the response
    xfer(1'b0, 5'h0C, 2'd2, 32'h0);
    chk("prerst_rdt", bus.rdt, 32'h0101_0000);
    bus.vld = 1'b1; bus.wen = 1'b0; bus.adr = 5'h0C; bus.siz = 2'd2;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rdt", bus.rdt, 32'h0);
    chk("midrst_exit_vld", {31'h0, exit_vld}, 32'h0);
    chk("midrst_exit_cod", {1'b0, exit_cod}, 32'h0);
    chk("midrst_con_vld", {31'h0, con_vld}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_rdt_held", bus.rdt, 32'h0);
    bus.vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl2[i]) apply_vec("b", i, tbl2[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
